// File: rtl/uart_rx.sv
// uart_rx -- 8-bit asynchronous serial receiver, LSB first, one stop bit.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between data bit 7 and the stop bit (frame becomes 8E1). Without it the
// frame is 8N1 and parity_err is tied low.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : asynchronous active-low reset
//   Din        : serial line, idle high, asynchronous to clk
//   data_out   : last correctly received byte (holds until the next valid)
//   valid      : one-cycle pulse when data_out is updated
//   busy       : high while a frame is being received (and while waiting
//                for the line to return high after a framing error)
//   frame_err  : one-cycle pulse on a bad (low) stop bit
//   parity_err : one-cycle pulse on a parity mismatch with a good stop bit
//   dbg_state  : current FSM state encoding, for observation only
//
// Handshake: valid, frame_err and parity_err are mutually exclusive
// single-cycle pulses; there is no ready input, so a consumer must capture
// data_out in the cycle valid is high or before the next valid.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_sdin_prev;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_sdin;
  logic            w_fall;

  assign w_sdin    = r_sync2;
  assign w_fall    = r_sdin_prev & ~w_sdin;
  assign dbg_state = r_state;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // Reset to 1 so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sdin_prev <= 1'b1;
    end else begin
      r_sync1     <= Din;
      r_sync2     <= r_sync1;
      r_sdin_prev <= r_sync2;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'h00;
      data_out     <= 8'h00;
      valid        <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      valid        <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_bit <= 3'd0;
          if (w_fall) begin
            r_state <= S_START;
            busy    <= 1'b1;
          end
        end

        // Wait half a bit past the detected edge so every later sample,
        // taken a full bit period apart, lands in the middle of a bit.
        S_START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt <= '0;
            if (!w_sdin) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_shift <= {w_sdin, r_shift[7:1]};
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit equals the XOR of the data bits.
        S_PARITY: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt     <= '0;
            r_par_bad <= w_sdin ^ (^r_shift);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
            if (w_sdin) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else begin
                data_out <= r_shift;
                valid    <= 1'b1;
              end
`else
              data_out <= r_shift;
              valid    <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Line held low past the stop bit (break): stay busy until it idles.
        S_WAIT_IDLE: begin
          if (w_sdin) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed, table-driven bench for uart_rx at CLKS_PER_BIT=16.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Sync flops + IDLE->START cycle, half a bit, then the remaining bits.
  localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  logic       clk;
  logic       rst;
  logic       Din;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic [2:0] dbg_state;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .Din        (Din),
    .data_out   (data_out),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_pass;
  int         n_total;
  logic [7:0] exp_q[$];
  int         n_valid;
  int         n_ferr;
  int         n_perr;
  int         n_long;
  logic       prev_v;
  logic       prev_f;
  logic       prev_p;
  logic [7:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_ferr  = 0;
    n_perr  = 0;
  endtask

  // Pulse monitor: every valid pops the expected queue; any output pulse
  // lasting two consecutive cycles is recorded as a long pulse.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        exp_b = exp_q.pop_front();
        check("data_out_on_valid", 32'(data_out), 32'(exp_b));
      end
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if ((valid && prev_v) || (frame_err && prev_f) || (parity_err && prev_p)) n_long++;
    prev_v = valid;
    prev_f = frame_err;
    prev_p = parity_err;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now (always called at posedge+1). Leaves
  // Din at the stop level; the caller returns the line high.
  task automatic send_frame(input logic [7:0] d, input bit par_flip,
                            input logic stop_lvl, input int stop_cycles);
    Din = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      Din = d[i];
      wait_cycles(CPB);
    end
`ifdef UART_RX_PARITY_EN
    Din = (^d) ^ par_flip;
    wait_cycles(CPB);
`else
    if (par_flip) Din = 1'b1;
`endif
    Din = stop_lvl;
    wait_cycles(stop_cycles);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[4];
  int   lat;
  bit   saw_low;

  initial begin
    n_pass  = 0;
    n_total = 0;
    n_long  = 0;
    prev_v  = 1'b0;
    prev_f  = 1'b0;
    prev_p  = 1'b0;
    clear_counts();

    // Expected data_out after each entry: a bad stop keeps the prior byte.
    vecs[0] = '{8'h12, 1'b1, 1, 0, 8'h12};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'h12};
    vecs[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'hF0, 1'b0, 0, 1, 8'h81};

    // Reset state
    rst = 1'b0;
    Din = 1'b1;
    wait_cycles(4);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    wait_cycles(4);

    // Latency with 0xA5: edge 0 is the first posedge that samples Din low.
    clear_counts();
    exp_q.push_back(8'hA5);
    lat = -1;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, CPB);
      begin
        for (int k = 0; k < LAT + 40; k++) begin
          @(posedge clk);
          #1;
          if (valid && lat < 0) lat = k;
        end
      end
    join
    Din = 1'b1;
    wait_cycles(10);
    check("latency_a5", 32'(lat), 32'(LAT));
    check("a5_valid_count", 32'(n_valid), 32'd1);
    check("a5_frame_err_count", 32'(n_ferr), 32'd0);
    check("a5_data_out", 32'(data_out), 32'hA5);

    // Table: good and bad stop bits
    for (int v = 0; v < 4; v++) begin
      clear_counts();
      if (vecs[v].stop_ok) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, 1'b0, vecs[v].stop_ok, vecs[v].stop_ok ? CPB : 40);
      if (!vecs[v].stop_ok) check($sformatf("vec%0d_busy_in_break", v), 32'(busy), 32'd1);
      Din = 1'b1;
      wait_cycles(5);
      check($sformatf("vec%0d_busy_after", v), 32'(busy), 32'd0);
      wait_cycles(10);
      check($sformatf("vec%0d_valid_count", v), 32'(n_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_frame_err_count", v), 32'(n_ferr), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_data_out", v), 32'(data_out), 32'(vecs[v].exp_dout));
    end

    // Back-to-back 0x00 then 0xFF with no idle gap
    clear_counts();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b0, 1'b1, CPB);
    send_frame(8'hFF, 1'b0, 1'b1, CPB);
    Din = 1'b1;
    wait_cycles(20);
    check("b2b_valid_count", 32'(n_valid), 32'd2);
    check("b2b_data_out", 32'(data_out), 32'hFF);

    // False start: 4-cycle low glitch
    clear_counts();
    Din = 1'b0;
    wait_cycles(4);
    Din = 1'b1;
    check("glitch_busy_set", 32'(busy), 32'd1);
    saw_low = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (!busy) saw_low = 1'b1;
    end
    check("glitch_busy_cleared", 32'(saw_low), 32'd1);
    wait_cycles(20);
    check("glitch_valid_count", 32'(n_valid), 32'd0);
    check("glitch_frame_err_count", 32'(n_ferr), 32'd0);
    check("glitch_data_out", 32'(data_out), 32'hFF);

    // Reset during bit 4 of 0x77, then receive 0x5A
    clear_counts();
    Din = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      Din = (8'h77 >> i) & 8'h01;
      wait_cycles(CPB);
    end
    Din = 1'b1;
    wait_cycles(CPB / 2);
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(5);
    check("post_rst_valid_count", 32'(n_valid), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, CPB);
    Din = 1'b1;
    wait_cycles(20);
    check("rst_recover_valid_count", 32'(n_valid), 32'd1);
    check("rst_recover_data_out", 32'(data_out), 32'h5A);
    check("rst_recover_frame_err", 32'(n_ferr), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x03 has even parity bit 0
    clear_counts();
    send_frame(8'h03, 1'b1, 1'b1, CPB);
    Din = 1'b1;
    wait_cycles(20);
    check("par_bad_perr_count", 32'(n_perr), 32'd1);
    check("par_bad_valid_count", 32'(n_valid), 32'd0);
    check("par_bad_data_out", 32'(data_out), 32'h5A);
    clear_counts();
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b0, 1'b1, CPB);
    Din = 1'b1;
    wait_cycles(20);
    check("par_good_perr_count", 32'(n_perr), 32'd0);
    check("par_good_valid_count", 32'(n_valid), 32'd1);
    check("par_good_data_out", 32'(data_out), 32'h03);
`else
    check("parity_err_total", 32'(n_perr), 32'd0);
`endif

    // Pulse widths and leftover expectations
    check("long_pulses", 32'(n_long), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
